snake_vga_reader: RTL
=====================

Name: snake_vga_reader

Overview:
- Read side of the shared game-state memory: consumes `snake_head_pos`, `apple_pos`, `num_tails` and the tail table that `game_logic` writes, and produces 640x480@60 VGA signals.
- The screen is a 40x30 grid of 16x16-pixel cells.
- Sits between `snake_memory` and the VGA pins in `SnakeGame`. It is clocked by `gl_clk` (25 MHz pixel clock), one pixel per clock.

Parameters:
- X_W, 6, width of the cell X coordinate (position word bits [X_W-1:0]).
- Y_W, 5, width of the cell Y coordinate (position word bits [X_W+Y_W-1:X_W]).
- TAILS_W, 6, width of `num_tails` and `tail_addr`; maximum 63 tails.
- GRID_COLS, 40, number of visible cell columns.
- GRID_ROWS, 30, number of visible cell rows.

Ports:
- clk  in  1  pixel clock (`gl_clk`).
- reset  in  1  synchronous, active-high reset.
- snake_head_pos  in  X_W+Y_W  head cell {y,x}.
- apple_pos  in  X_W+Y_W  apple cell {y,x}.
- num_tails  in  TAILS_W  valid tail entries at addresses 0..num_tails-1.
- tail_addr  out  TAILS_W  tail table read address.
- tail_rd_en  out  1  read strobe.
- tail_value  in  X_W+Y_W  tail {y,x}; valid exactly 1 clk after the `tail_rd_en` cycle.
- vga_hsync  out  1  active-low horizontal sync.
- vga_vsync  out  1  active-low vertical sync.
- vga_r, vga_g, vga_b  out  4 each  colour.
- frame_tick  out  1  1-clk pulse at start of vertical blank.
- in_vblank  out  1  high while v_cnt >= 480.

Behaviour:
- Interface (already decided): one clock `clk`; reset is synchronous and active-high; port name `reset`. All registers clear on reset, including mid-line or mid-read.
- Reset values: hsync=1, vsync=1, rgb=0, tail_rd_en=0, tail_addr=0, frame_tick=0, in_vblank=0, h_cnt=v_cnt=0, both row bitmaps=0, FSM=IDLE.
- Horizontal timing: h_cnt 0..799 (640 visible, FP 16, sync 96, BP 48). hsync low for h_cnt 656..751.
- Vertical timing: v_cnt 0..524, increments when h_cnt wraps (480 visible, FP 10, sync 2, BP 33). vsync low for v_cnt 490..491.
- Snapshot:
  - At h_cnt=0, v_cnt=480: latch head, apple and num_tails into shadow registers; pulse frame_tick.
  - The whole next frame renders from the shadows. Input changes mid-frame are invisible until the next snapshot.
- Row-bitmap FSM (IDLE, READ, DRAIN):
  - IDLE -> READ at h_cnt=640, only if the next line (v_cnt+1, wrapping 524->0) is visible. In the same cycle, clear the build bitmap (GRID_COLS bits) and set target row = next_v>>4.
  - If shadow num_tails=0, go directly IDLE -> DRAIN.
  - READ: assert tail_rd_en with tail_addr=i for i=0..n-1, one per clk, back-to-back.
  - Data for address i is evaluated on the following clk: if its y equals the target row and x < GRID_COLS, set build bit x. Entries with y >= GRID_ROWS or x >= GRID_COLS are ignored.
  - After the last address: go to DRAIN for 1 clk to capture the final data, then IDLE.
  - Worst case is 65 clks, well within the 160-clk hblank.
- Bitmap swap: at h_cnt=799 copy the build bitmap to the display bitmap, only if the FSM ran this line.
- Tail reads occur only during hblank. Line 524 builds row 0.
- Pixel pipeline:
  - Cell = (h_cnt>>4, v_cnt>>4).
  - Colour priority: head (F,F,0) > apple (F,0,0) > tail bit set (0,C,0) > background (0,0,0). Blanking forces 0.
  - Colour and sync outputs are registered, so all VGA outputs lag the counters by exactly 1 clk and stay mutually aligned.
  - A head or apple coordinate outside the grid is not drawn.
- `in_vblank` and `frame_tick` are registered and also lag the counters by 1 clk.

Optional Feature:
- GRID_LINES_EN defined: background pixels with h_cnt[3:0]=0 or v_cnt[3:0]=0 render (2,2,2). Occupied cells are unaffected.
- Undefined: background is pure black. Logic and timing are otherwise identical.

Test Plan:
- Reset then free-run 2 frames:
  - hsync low 96 clks per line, period 800.
  - vsync low 1600 clks, period 420000.
  - frame_tick exactly once per 420000 clks.
  - rgb=0 whenever blanking.
- head=(x=0,y=0), apple=(39,29), num_tails=0:
  - Output pixel (0,0)..(15,15) = (F,F,0).
  - Pixel (639,479) = (F,0,0).
  - tail_rd_en never asserts.
- num_tails=3, tails (5,0),(6,0),(5,1):
  - Line 524 issues addr 0,1,2 at h_cnt 640,641,642.
  - Cells (5,0),(6,0) render green on row 0; (5,1) renders green on row 1.
- Head and apple both at (10,10); tail also (10,10): cell renders head colour.
- Tail entry (45,3) and head y=31: nothing drawn, no X-propagation.
- Change head mid-frame at v_cnt=200: display is unchanged until after the next frame_tick.
- Assert reset at h_cnt=642 during a read burst:
  - Next clk tail_rd_en=0 and counters are 0.
  - Bitmaps are cleared, so no stale tails render on the next frame.

Source files
------------

// File: rtl/snake_vga_reader.sv
// 640x480@60 VGA scan-out of the snake game state, one pixel per clk on a 40x30 grid of 16x16 cells.
// Optional macro GRID_LINES_EN draws dim grid lines on background cells.
module snake_vga_reader #(
    parameter int X_W       = 6,
    parameter int Y_W       = 5,
    parameter int TAILS_W   = 6,
    parameter int GRID_COLS = 40,
    parameter int GRID_ROWS = 30
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [X_W+Y_W-1:0]   snake_head_pos,
    input  logic [X_W+Y_W-1:0]   apple_pos,
    input  logic [TAILS_W-1:0]   num_tails,
    output logic [TAILS_W-1:0]   tail_addr,
    output logic                 tail_rd_en,
    input  logic [X_W+Y_W-1:0]   tail_value,
    output logic                 vga_hsync,
    output logic                 vga_vsync,
    output logic [3:0]           vga_r,
    output logic [3:0]           vga_g,
    output logic [3:0]           vga_b,
    output logic                 frame_tick,
    output logic                 in_vblank
);

    localparam logic [9:0] H_VIS    = 10'd640;
    localparam logic [9:0] H_SYNC_S = 10'd656;
    localparam logic [9:0] H_SYNC_E = 10'd751;
    localparam logic [9:0] H_MAX    = 10'd799;
    localparam logic [9:0] V_VIS    = 10'd480;
    localparam logic [9:0] V_SYNC_S = 10'd490;
    localparam logic [9:0] V_SYNC_E = 10'd491;
    localparam logic [9:0] V_MAX    = 10'd524;
    localparam logic [X_W-1:0] COLS = X_W'(GRID_COLS);
    localparam logic [Y_W-1:0] ROWS = Y_W'(GRID_ROWS);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_e;

    logic [9:0]           h_cnt_q, v_cnt_q;
    logic [9:0]           next_v;
    logic [X_W+Y_W-1:0]   head_sh_q, apple_sh_q;
    logic [TAILS_W-1:0]   ntails_sh_q;
    state_e               state_q;
    logic [GRID_COLS-1:0] build_q, disp_q;
    logic [Y_W-1:0]       target_q;
    logic                 ran_q, rd_en_q, rd_vld_q;
    logic [TAILS_W-1:0]   addr_q;
    logic                 hsync_q, vsync_q, ftick_q, vblank_q;
    logic [11:0]          rgb_q, rgb_d;

    logic                 snap;
    logic                 vis;
    logic [X_W-1:0]       cx, head_x, apple_x, tv_x;
    logic [Y_W-1:0]       cy, head_y, apple_y, tv_y;
    logic                 head_hit, apple_hit, tail_hit;

    assign next_v  = (v_cnt_q == V_MAX) ? 10'd0 : v_cnt_q + 10'd1;
    assign snap    = (h_cnt_q == 10'd0) && (v_cnt_q == V_VIS);
    assign vis     = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    assign cx      = h_cnt_q[4 +: X_W];
    assign cy      = v_cnt_q[4 +: Y_W];
    assign head_x  = head_sh_q[X_W-1:0];
    assign head_y  = head_sh_q[X_W +: Y_W];
    assign apple_x = apple_sh_q[X_W-1:0];
    assign apple_y = apple_sh_q[X_W +: Y_W];
    assign tv_x    = tail_value[X_W-1:0];
    assign tv_y    = tail_value[X_W +: Y_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else if (h_cnt_q == H_MAX) begin
            h_cnt_q <= '0;
            v_cnt_q <= next_v;
        end else begin
            h_cnt_q <= h_cnt_q + 10'd1;
        end
    end

    // Shadows hold the whole next frame stable against mid-frame game updates.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_sh_q   <= '0;
            apple_sh_q  <= '0;
            ntails_sh_q <= '0;
        end else if (snap) begin
            head_sh_q   <= snake_head_pos;
            apple_sh_q  <= apple_pos;
            ntails_sh_q <= num_tails;
        end
    end

    // Launch one clk early so the first strobe coincides with h_cnt=640.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            build_q  <= '0;
            disp_q   <= '0;
            target_q <= '0;
            ran_q    <= 1'b0;
            rd_en_q  <= 1'b0;
            rd_vld_q <= 1'b0;
            addr_q   <= '0;
        end else begin
            rd_vld_q <= rd_en_q;
            if (rd_vld_q && (tv_y == target_q) && (tv_x < COLS))
                build_q[tv_x] <= 1'b1;
            case (state_q)
                IDLE: begin
                    if ((h_cnt_q == H_VIS - 10'd1) && (next_v < V_VIS)) begin
                        build_q  <= '0;
                        target_q <= next_v[4 +: Y_W];
                        ran_q    <= 1'b1;
                        addr_q   <= '0;
                        if (ntails_sh_q == '0) begin
                            state_q <= DRAIN;
                        end else begin
                            state_q <= READ;
                            rd_en_q <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (addr_q == ntails_sh_q - 1'b1) begin
                        rd_en_q <= 1'b0;
                        state_q <= DRAIN;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                    end
                end
                DRAIN:   state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            if ((h_cnt_q == H_MAX) && ran_q) begin
                disp_q <= build_q;
                ran_q  <= 1'b0;
            end
        end
    end

    assign head_hit  = (head_x == cx) && (head_y == cy) && (head_x < COLS) && (head_y < ROWS);
    assign apple_hit = (apple_x == cx) && (apple_y == cy) && (apple_x < COLS) && (apple_y < ROWS);
    assign tail_hit  = (cx < COLS) && disp_q[cx];

    always_comb begin
        rgb_d = 12'h000;
        if (vis) begin
            if (head_hit)       rgb_d = 12'hFF0;
            else if (apple_hit) rgb_d = 12'hF00;
            else if (tail_hit)  rgb_d = 12'h0C0;
`ifdef GRID_LINES_EN
            else if ((h_cnt_q[3:0] == 4'd0) || (v_cnt_q[3:0] == 4'd0)) rgb_d = 12'h222;
`else
            else rgb_d = 12'h000;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            rgb_q    <= '0;
            ftick_q  <= 1'b0;
            vblank_q <= 1'b0;
        end else begin
            hsync_q  <= !((h_cnt_q >= H_SYNC_S) && (h_cnt_q <= H_SYNC_E));
            vsync_q  <= !((v_cnt_q >= V_SYNC_S) && (v_cnt_q <= V_SYNC_E));
            rgb_q    <= rgb_d;
            ftick_q  <= snap;
            vblank_q <= (v_cnt_q >= V_VIS);
        end
    end

    assign tail_addr  = addr_q;
    assign tail_rd_en = rd_en_q;
    assign vga_hsync  = hsync_q;
    assign vga_vsync  = vsync_q;
    assign vga_r      = rgb_q[11:8];
    assign vga_g      = rgb_q[7:4];
    assign vga_b      = rgb_q[3:0];
    assign frame_tick = ftick_q;
    assign in_vblank  = vblank_q;

endmodule
